// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM DMA sequencer: default widths, command op codes
// and the FSM state encoding.
package ram_dma_pkg;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 8;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_COPY = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/ram_dma_ctrl_if.sv
// RAM port bundle between the DMA sequencer (master) and the single-port RAM (slave).
interface ram_dma_ctrl_if #(
    parameter int AW = ram_dma_pkg::AW_DEF,
    parameter int DW = ram_dma_pkg::DW_DEF
);

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/ram_dma_ctrl.sv
// FILL/COPY command sequencer that owns the port of a sync-read single-port RAM.
// Optional build macro RAM_DMA_CHECKSUM_EN adds a byte-sum of the last command's writes.
module ram_dma_ctrl
    import ram_dma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
`ifdef RAM_DMA_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    ram_dma_ctrl_if.master mem
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [AW:0]   offset_q, offset_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // Address and write data are registered from the next-state decode so the
    // RAM sees clean, glitch-free values and wdata holds outside WR.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        fill_d      = fill_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d        = op_e'(op);
                    src_d       = src;
                    dst_d       = dst;
                    fill_d      = fill_val;
                    offset_d    = '0;
                    remaining_d = len;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else if (op_e'(op) == OP_FILL) begin
                        state_d = ST_WR;
                        addr_d  = dst;
                        wdata_d = fill_val;
                    end else begin
                        state_d = ST_RD;
                        addr_d  = src;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The write-data register doubles as the captured read-data register.
                state_d = ST_WR;
                wdata_d = mem.mem_rdata;
                addr_d  = dst_q + offset_q[AW-1:0];
            end
            ST_WR: begin
                offset_d    = offset_q + (AW+1)'(1);
                remaining_d = remaining_q - (AW+1)'(1);
                if (remaining_q == (AW+1)'(1)) begin
                    state_d = ST_DONE;
                end else if (op_q == OP_FILL) begin
                    addr_d = dst_q + offset_d[AW-1:0];
                end else begin
                    state_d = ST_RD;
                    addr_d  = src_q + offset_d[AW-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_FILL;
            src_q       <= '0;
            dst_q       <= '0;
            fill_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            fill_q      <= fill_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy          = (state_q == ST_RD) || (state_q == ST_WAIT) || (state_q == ST_WR);
    assign done          = (state_q == ST_DONE);
    assign mem.mem_we    = (state_q == ST_WR);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

`ifdef RAM_DMA_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    // Accumulates exactly the bytes presented on WR cycles; frozen once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            sum_q <= '0;
        end else if (state_q == ST_WR) begin
            sum_q <= sum_q + wdata_q;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_ram_dma_ctrl.sv
// Self-checking bench for ram_dma_ctrl: command table plus write scoreboard against a
// behavioural 128x8 sync-read RAM and a shadow copy of its expected contents.
module tb_ram_dma_ctrl;
    import ram_dma_pkg::*;

    typedef struct {
        logic       op;
        logic [6:0] src;
        logic [6:0] dst;
        logic [7:0] len;
        logic [7:0] fill;
        int         exp_done;  // cycle index of the done pulse, 1 = first cycle after accept
        int         exp_busy;  // number of cycles with busy high
    } vec_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
    logic [6:0] src;
    logic [6:0] dst;
    logic [7:0] len;
    logic [7:0] fill_val;
    logic       busy;
    logic       done;
`ifdef RAM_DMA_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic       ram_init;
    logic       pre_we;
    logic [6:0] pre_addr;
    logic [7:0] pre_data;
    logic [7:0] ram [128];
    logic [7:0] shadow [128];

    wr_t  exp_q [$];
    vec_t vecs [9];
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    int   extra_writes = 0;
    logic [7:0] last_wd = 8'h00;

    ram_dma_ctrl_if #(.AW(7), .DW(8)) mem_bus ();

    ram_dma_ctrl #(.AW(7), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
`ifdef RAM_DMA_CHECKSUM_EN
        .checksum (checksum),
`endif
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: read-before-write, data_out valid one clock after address.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) ram[i] <= 8'(i * 3 + 1);
        end else if (mem_bus.mem_we) begin
            ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
        mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called once per cycle, #1 after the rising edge.
    task automatic sample_cycle();
        wr_t w;
        if (mem_bus.mem_we === 1'b1) begin
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("wr_addr", mem_bus.mem_addr, w.addr);
                check("wr_data", mem_bus.mem_wdata, w.data);
                last_wd = w.data;
            end else begin
                extra_writes++;
            end
        end else begin
            check("wdata_hold", mem_bus.mem_wdata, last_wd);
        end
    endtask

    task automatic compare_ram(input string tag);
        for (int a = 0; a < 128; a++) begin
            check($sformatf("%s_ram[%0d]", tag, a), ram[a], shadow[a]);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        logic [6:0] a_s, a_d;
        logic [7:0] d;
        logic [7:0] sum;
        int done_k, busy_n;
        string tag;
        tag = $sformatf("v%0d", idx);
        sum = 8'h00;
        extra_writes = 0;
        @(negedge clk);
        op = v.op; src = v.src; dst = v.dst; len = v.len; fill_val = v.fill; start = 1'b1;
        for (int i = 0; i < int'(v.len); i++) begin
            a_s = v.src + 7'(i);
            a_d = v.dst + 7'(i);
            d = (v.op == OP_COPY) ? shadow[a_s] : v.fill;
            shadow[a_d] = d;
            exp_q.push_back('{addr: a_d, data: d});
            sum = sum + d;
        end
        @(posedge clk); #1;
        start = 1'b0;
        done_k = 0;
        busy_n = 0;
        for (int k = 1; k <= 400; k++) begin
            sample_cycle();
            if (busy === 1'b1) busy_n++;
`ifdef RAM_DMA_CHECKSUM_EN
            if (k == 1) check({tag, "_cksum_clear"}, checksum, 8'h00);
`endif
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done_cycle"}, done_k, v.exp_done);
        check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
        @(posedge clk); #1;
        check({tag, "_done_width"}, done, 1'b0);
        sample_cycle();
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_extra_writes"}, extra_writes, 0);
`ifdef RAM_DMA_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, sum);
`endif
        compare_ram(tag);
        exp_q.delete();
    endtask

    // COPY len=5 aborted by reset during its second WR cycle; a start while busy is ignored.
    task automatic reset_mid_copy();
        logic [7:0] d;
        int done_seen;
        done_seen = 0;
        extra_writes = 0;
        @(negedge clk);
        op = 1'b1; src = 7'd60; dst = 7'd70; len = 8'd5; fill_val = 8'h00; start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = shadow[7'd60 + 7'(i)];
            shadow[7'd70 + 7'(i)] = d;
            exp_q.push_back('{addr: 7'd70 + 7'(i), data: d});
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sample_cycle();
            if (done === 1'b1) done_seen++;
            if (k == 2) begin
                start = 1'b1; op = 1'b0; dst = 7'd0; len = 8'd1; fill_val = 8'hEE;
            end
            if (k == 3) start = 1'b0;
            if (k == 6) check("rst_mid_second_wr", mem_bus.mem_we, 1'b1);
            if (k < 6) begin
                @(posedge clk); #1;
            end
        end
        check("rst_mid_writes_before_abort", exp_q.size(), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_we", mem_bus.mem_we, 1'b0);
        check("rst_mid_addr", mem_bus.mem_addr, 7'd0);
        check("rst_mid_wdata", mem_bus.mem_wdata, 8'h00);
        last_wd = 8'h00;
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            sample_cycle();
            if (done === 1'b1) done_seen++;
        end
        check("rst_mid_no_done", done_seen, 0);
        check("rst_mid_no_more_writes", extra_writes, 0);
        compare_ram("rst_mid");
        exp_q.delete();
    endtask

    initial begin
        //          op       src     dst      len      fill   done busy
        vecs[0] = '{OP_FILL, 7'd0,   7'd10,  8'd3,   8'hAA,   4,   3};
        vecs[1] = '{OP_COPY, 7'd20,  7'd40,  8'd2,   8'h00,   7,   6};
        vecs[2] = '{OP_FILL, 7'd0,   7'd126, 8'd4,   8'h0F,   5,   4};
        vecs[3] = '{OP_FILL, 7'd0,   7'd2,   8'd0,   8'hFF,   1,   0};
        vecs[4] = '{OP_COPY, 7'd5,   7'd90,  8'd0,   8'h00,   1,   0};
        vecs[5] = '{OP_COPY, 7'd50,  7'd52,  8'd4,   8'h00,  13,  12};
        vecs[6] = '{OP_COPY, 7'd125, 7'd3,   8'd5,   8'h00,  16,  15};
        vecs[7] = '{OP_FILL, 7'd0,   7'd100, 8'd1,   8'h3C,   2,   1};
        vecs[8] = '{OP_FILL, 7'd0,   7'd51,  8'd128, 8'h5A, 129, 128};

        rst = 1'b1; ram_init = 1'b1; start = 1'b0; op = 1'b0;
        src = '0; dst = '0; len = '0; fill_val = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 128; i++) shadow[i] = 8'(i * 3 + 1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_we", mem_bus.mem_we, 1'b0);
        check("reset_addr", mem_bus.mem_addr, 7'd0);
        check("reset_wdata", mem_bus.mem_wdata, 8'h00);
`ifdef RAM_DMA_CHECKSUM_EN
        check("reset_checksum", checksum, 8'h00);
`endif
        rst = 1'b0;
        ram_init = 1'b0;

        preload(7'd20, 8'h55);
        preload(7'd21, 8'h66);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

        reset_mid_copy();
        run_cmd(vecs[0], 9);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
